// File: rtl/rv_hart_scheduler.sv
// rv_hart_scheduler: per-hart run state, round-robin issue of one READY hart per cycle, and a
// PIPE_DEPTH delay line steering writeback. Define RV_HART_SCHED_MIN_GAP_EN for per-hart issue spacing.
module rv_hart_scheduler #(
    parameter int NUM_HARTS  = 8,
    parameter int HART_W     = 3,
    parameter int PIPE_DEPTH = 4,
    parameter int BOOT_HART  = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_HARTS-1:0]   hart_start,
    input  logic [NUM_HARTS-1:0]   hart_stop,
    input  logic [NUM_HARTS-1:0]   hart_block,
    input  logic [NUM_HARTS-1:0]   hart_unblock,
    input  logic                   stall,
    output logic                   issue_valid,
    output logic [HART_W-1:0]      issue_hart,
    output logic                   wb_valid,
    output logic [HART_W-1:0]      wb_hart,
    output logic [2*NUM_HARTS-1:0] hart_state
);
    typedef enum logic [1:0] {OFF = 2'b00, READY = 2'b01, WAIT = 2'b10} state_t;

    state_t                st [NUM_HARTS];
    state_t                st_nxt [NUM_HARTS];
    logic [NUM_HARTS-1:0]  elig;
    logic [HART_W-1:0]     rr_last;
    logic [HART_W-1:0]     grant;
    logic                  found;
    logic [PIPE_DEPTH-1:0] pipe_v;
    logic [HART_W-1:0]     pipe_h [PIPE_DEPTH];

`ifdef RV_HART_SCHED_MIN_GAP_EN
    localparam int GW = 4;
    logic [GW-1:0] gap [NUM_HARTS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_HARTS; i++) gap[i] <= '0;
        end else if (!stall) begin
            for (int i = 0; i < NUM_HARTS; i++)
                gap[i] <= (found && grant == HART_W'(i)) ? GW'(PIPE_DEPTH - 1) : gap[i] - GW'(gap[i] != '0);
        end
    end
`endif

    // A hart being blocked or stopped this cycle is already withheld from selection.
    always_comb begin
        hart_state = '0;
        for (int i = 0; i < NUM_HARTS; i++) begin
            st_nxt[i] = st[i];
            if (hart_stop[i]) st_nxt[i] = OFF;
            else if (hart_start[i]) st_nxt[i] = (st[i] == OFF) ? READY : st[i];
            else if (hart_block[i]) st_nxt[i] = (st[i] == READY) ? WAIT : st[i];
            else if (hart_unblock[i]) st_nxt[i] = (st[i] == WAIT) ? READY : st[i];
            elig[i] = st[i] == READY && !hart_block[i] && !hart_stop[i];
`ifdef RV_HART_SCHED_MIN_GAP_EN
            elig[i] = elig[i] && gap[i] == '0;
`endif
            hart_state[2*i +: 2] = st[i];
        end
    end

    // Scan from farthest to nearest so the nearest eligible hart after rr_last wins.
    always_comb begin
        grant = rr_last;
        found = 1'b0;
        for (int i = NUM_HARTS; i >= 1; i--) begin
            if (elig[HART_W'(int'(rr_last) + i)]) begin
                grant = HART_W'(int'(rr_last) + i);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_HARTS; i++) st[i] <= (i == BOOT_HART) ? READY : OFF;
            issue_valid <= 1'b0;
            issue_hart  <= '0;
            rr_last     <= HART_W'(NUM_HARTS - 1);
            pipe_v      <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) pipe_h[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_HARTS; i++) st[i] <= st_nxt[i];
            if (!stall) begin
                issue_valid <= found;
                if (found) begin
                    issue_hart <= grant;
                    rr_last    <= grant;
                end
                pipe_v[0] <= issue_valid;
                pipe_h[0] <= issue_hart;
                for (int i = 1; i < PIPE_DEPTH; i++) begin
                    pipe_v[i] <= pipe_v[i-1];
                    pipe_h[i] <= pipe_h[i-1];
                end
            end
        end
    end

    assign wb_valid = pipe_v[PIPE_DEPTH-1];
    assign wb_hart  = pipe_h[PIPE_DEPTH-1];
endmodule

// File: tb/tb_rv_hart_scheduler.sv
// tb_rv_hart_scheduler: directed stimulus pushes expected issue results into a scoreboard queue;
// a negedge monitor pops on each advancing cycle and checks issue_* and the delayed wb_*.
module tb_rv_hart_scheduler;
    localparam int N = 8;
    localparam int W = 3;
    localparam int D = 4;
`ifdef RV_HART_SCHED_MIN_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [N-1:0] hart_start = '0, hart_stop = '0, hart_block = '0, hart_unblock = '0;
    logic stall = 1'b0;
    logic issue_valid, wb_valid;
    logic [W-1:0] issue_hart, wb_hart;
    logic [2*N-1:0] hart_state;

    int checks = 0;
    int failures = 0;
    logic [W:0] sb [$];
    logic [W:0] cur = '0;
    logic [W:0] hq [D];
    logic adv = 1'b0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    rv_hart_scheduler #(.NUM_HARTS(N), .HART_W(W), .PIPE_DEPTH(D), .BOOT_HART(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .hart_start(hart_start), .hart_stop(hart_stop),
        .hart_block(hart_block), .hart_unblock(hart_unblock),
        .stall(stall),
        .issue_valid(issue_valid), .issue_hart(issue_hart),
        .wb_valid(wb_valid), .wb_hart(wb_hart),
        .hart_state(hart_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected issue_valid for the k-th cycle after a lone hart was last granted.
    function automatic logic single_v(input int k);
        return (k % D == 0) || !GAP_EN;
    endfunction

    always @(posedge clk) adv <= mon_en && !stall;

    always @(negedge clk) begin
        if (mon_en) begin
            if (adv) begin
                for (int i = D - 1; i > 0; i--) hq[i] = hq[i-1];
                hq[0] = cur;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_underflow: got empty queue expected an entry at %0t", $time);
                end else cur = sb.pop_front();
            end
            check("issue", {issue_valid, issue_hart}, cur);
            check("wb", {wb_valid, wb_hart}, hq[D-1]);
        end
    end

    task automatic step(input logic [N-1:0] st, input logic [N-1:0] sp, input logic [N-1:0] bl,
                        input logic [N-1:0] ub, input logic stl, input logic v, input logic [W-1:0] h);
        hart_start = st;
        hart_stop = sp;
        hart_block = bl;
        hart_unblock = ub;
        stall = stl;
        if (!stl) sb.push_back({v, h});
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int h);
        step('0, '0, '0, '0, 1'b0, 1'b1, W'(h));
    endtask

    initial begin
        for (int i = 0; i < D; i++) hq[i] = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_issue_valid", issue_valid, 0);
        check("rst_issue_hart", issue_hart, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_hart", wb_hart, 0);
        check("rst_hart_state", hart_state, 16'h0001);
        rst_n = 1'b1;
        mon_en = 1'b1;
        // boot hart alone
        for (int k = 0; k < 8; k++) step('0, '0, '0, '0, 1'b0, single_v(k), 0);
        // start all harts; start is visible to selection one cycle later
        step(8'hFF, '0, '0, '0, 1'b0, 1'b1, 0);
        for (int k = 1; k <= 10; k++) go(k % 8);
        // block hart 3 while hart 2 is issuing
        step('0, '0, 8'h08, '0, 1'b0, 1'b1, 4);
        for (int k = 5; k <= 10; k++) go(k % 8);
        go(4);
        check("hart3_wait", hart_state[7:6], 2'b10);
        step('0, '0, '0, 8'h08, 1'b0, 1'b1, 5);
        for (int k = 6; k <= 12; k++) go(k % 8);
        check("hart3_ready", hart_state[7:6], 2'b01);
        // stall freezes issue and delay line
        repeat (3) step('0, '0, '0, '0, 1'b1, 1'b0, 0);
        for (int k = 5; k <= 7; k++) go(k);
        // stop beats start on hart 5
        step(8'h20, 8'h20, '0, '0, 1'b0, 1'b1, 0);
        for (int k = 1; k <= 4; k++) go(k);
        go(6);
        check("hart5_off", hart_state[11:10], 2'b00);
        step('0, '0, 8'h04, '0, 1'b0, 1'b1, 7);
        go(0);
        go(1);
        go(3);
        check("hart2_wait", hart_state[5:4], 2'b10);
        // block with unblock on a WAIT hart keeps it waiting
        step('0, '0, 8'h04, 8'h04, 1'b0, 1'b1, 4);
        go(6);
        go(7);
        go(0);
        check("hart2_still_wait", hart_state[5:4], 2'b10);
        check("state_mix", hart_state, 16'h5165);
        // lone hart 0 again
        step('0, 8'hFE, '0, '0, 1'b0, single_v(1), 0);
        for (int k = 2; k <= 9; k++) step('0, '0, '0, '0, 1'b0, single_v(k), 0);
        check("only_hart0", hart_state, 16'h0001);
        @(negedge clk);
        #1;
        check("sb_drained", sb.size(), 0);
        // asynchronous reset mid-operation
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_wb_valid", wb_valid, 0);
        check("midrst_issue_valid", issue_valid, 0);
        check("midrst_state", hart_state, 16'h0001);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
